byte_unstriping_rx: RTL and testbench

Parametrised receive-side byte un-striper for the multi-lane link. It accepts words from `LANES` independent lanes, each with its own valid, into per-lane FIFOs. It then reassembles the original stream by draining the lanes strictly round-robin (lane 0, 1, …, `LANES-1`, 0, …) onto a single registered output with a valid flag. It replaces the fixed 4-lane, 8-bit, unbuffered receiver. It adds per-lane valids, lane skew absorption, overflow detection and optional lane alignment.

---
 rtl/byte_unstriping_rx_if.sv | 35 +++
 rtl/byte_unstriping_rx.sv | 200 ++++++++++++++++++++
 tb/tb_byte_unstriping_rx.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/byte_unstriping_rx_if.sv
// -----------------------------------------------------------------------------
// byte_unstriping_rx_if
// Bus bundle for the receive-side byte un-striper.
//   valid_in  [LANES]        per-lane word qualifier       (master -> slave)
//   data_in   [LANES*WIDTH]  lane i at [i*WIDTH +: WIDTH]  (master -> slave)
//   data_out  [WIDTH]        reassembled word              (slave -> master)
//   valid_out                data_out carries a new word   (slave -> master)
//   lane_out  [clog2(LANES)] lane that supplied data_out   (slave -> master)
//   overflow                 sticky lane-word drop flag    (slave -> master)
//   aligned                  round-robin draining active   (slave -> master)
// -----------------------------------------------------------------------------
interface byte_unstriping_rx_if #(
  parameter int WIDTH = 8,
  parameter int LANES = 4
);
  localparam int LW = $clog2(LANES);

  logic [LANES-1:0]       valid_in;
  logic [LANES*WIDTH-1:0] data_in;
  logic [WIDTH-1:0]       data_out;
  logic                   valid_out;
  logic [LW-1:0]          lane_out;
  logic                   overflow;
  logic                   aligned;

  modport master (
    output valid_in, data_in,
    input  data_out, valid_out, lane_out, overflow, aligned
  );

  modport slave (
    input  valid_in, data_in,
    output data_out, valid_out, lane_out, overflow, aligned
  );
endinterface

// File: rtl/byte_unstriping_rx.sv
// -----------------------------------------------------------------------------
// byte_unstriping_rx
// Receive-side byte un-striper. Each lane pushes its words into a private
// FIFO; the lanes are then drained strictly round-robin (0,1,..,LANES-1,0,..)
// onto one registered output. The stream never skips a lane: if the lane
// whose turn it is has nothing queued, output stalls until it does.
//
// Ports:
//   clk    in   single clock, rising edge
//   reset  in   asynchronous, active-low reset
//   bus    slave modport of byte_unstriping_rx_if (valid_in, data_in in;
//          data_out, valid_out, lane_out, overflow, aligned out)
//
// Parameters: WIDTH bits per lane word, LANES lane count (2..16),
//             DEPTH entries per lane FIFO (power of two, >= 2).
//
// Build option BYTE_UNSTRIPE_ALIGN_EN:
//   defined   - leave IDLE only when every lane FIFO holds a word (deskew)
//   undefined - leave IDLE as soon as lane 0's FIFO holds a word
// -----------------------------------------------------------------------------
module byte_unstriping_rx #(
  parameter int WIDTH = 8,
  parameter int LANES = 4,
  parameter int DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  byte_unstriping_rx_if.slave   bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int LW = $clog2(LANES);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // FIFO storage and bookkeeping (count is one bit wider than the pointers
  // so that full and empty are distinguishable)
  logic [WIDTH-1:0] mem_r    [LANES][DEPTH];
  logic [AW-1:0]    wr_ptr_r [LANES];
  logic [AW-1:0]    rd_ptr_r [LANES];
  logic [CW-1:0]    count_r  [LANES];

  state_t           state_r;
  state_t           state_next_s;
  logic [LW-1:0]    rr_r;
  logic [LW-1:0]    rr_next_s;

  logic [LANES-1:0] nonempty_s;
  logic [LANES-1:0] full_s;
  logic [LANES-1:0] pop_lane_s;
  logic [LANES-1:0] push_s;
  logic [LANES-1:0] drop_s;
  logic             start_s;
  logic             drain_s;
  logic             pop_s;
  logic [WIDTH-1:0] head_s;

  logic [WIDTH-1:0] data_out_r;
  logic             valid_out_r;
  logic [LW-1:0]    lane_out_r;
  logic             overflow_r;
  logic             aligned_r;

  // Per-lane FIFO status flags
  always_comb begin
    nonempty_s = {LANES{1'b0}};
    full_s     = {LANES{1'b0}};
    for (int i = 0; i < LANES; i++) begin
      nonempty_s[i] = (count_r[i] != {CW{1'b0}});
      full_s[i]     = (count_r[i] == CW'(DEPTH));
    end
  end

  // Start condition and FSM next-state
  always_comb begin
`ifdef BYTE_UNSTRIPE_ALIGN_EN
    start_s = &nonempty_s;
`else
    start_s = nonempty_s[0];
`endif
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (start_s) begin
          state_next_s = RUN;
        end else begin
          state_next_s = IDLE;
        end
      end
      RUN:     state_next_s = RUN;
      default: state_next_s = IDLE;
    endcase
  end

  // Round-robin pop decision; draining begins in the same cycle the start
  // condition is seen so the first word appears two edges after it arrived
  always_comb begin
    drain_s   = (state_next_s == RUN);
    pop_s     = drain_s && nonempty_s[rr_r];
    head_s    = mem_r[rr_r][rd_ptr_r[rr_r]];
    rr_next_s = rr_r;
    if (pop_s) begin
      if (rr_r == LW'(LANES - 1)) begin
        rr_next_s = {LW{1'b0}};
      end else begin
        rr_next_s = rr_r + LW'(1);
      end
    end else begin
      rr_next_s = rr_r;
    end
  end

  // Per-lane push/drop: a full lane still accepts a word if it pops this cycle
  always_comb begin
    pop_lane_s = {LANES{1'b0}};
    push_s     = {LANES{1'b0}};
    drop_s     = {LANES{1'b0}};
    for (int i = 0; i < LANES; i++) begin
      pop_lane_s[i] = pop_s && (rr_r == LW'(i));
      push_s[i]     = bus.valid_in[i] && (!full_s[i] || pop_lane_s[i]);
      drop_s[i]     = bus.valid_in[i] && full_s[i] && !pop_lane_s[i];
    end
  end

  // FIFO data storage; contents need no reset since pointers define validity
  always_ff @(posedge clk) begin
    for (int i = 0; i < LANES; i++) begin
      if (push_s[i]) begin
        mem_r[i][wr_ptr_r[i]] <= bus.data_in[i*WIDTH +: WIDTH];
      end
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < LANES; i++) begin
        wr_ptr_r[i] <= {AW{1'b0}};
        rd_ptr_r[i] <= {AW{1'b0}};
        count_r[i]  <= {CW{1'b0}};
      end
    end else begin
      for (int i = 0; i < LANES; i++) begin
        if (push_s[i]) begin
          wr_ptr_r[i] <= wr_ptr_r[i] + AW'(1);
        end
        if (pop_lane_s[i]) begin
          rd_ptr_r[i] <= rd_ptr_r[i] + AW'(1);
        end
        case ({push_s[i], pop_lane_s[i]})
          2'b10:   count_r[i] <= count_r[i] + CW'(1);
          2'b01:   count_r[i] <= count_r[i] - CW'(1);
          default: count_r[i] <= count_r[i];
        endcase
      end
    end
  end

  // FSM state and round-robin lane pointer
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= IDLE;
      rr_r    <= {LW{1'b0}};
    end else begin
      state_r <= state_next_s;
      rr_r    <= rr_next_s;
    end
  end

  // Registered outputs; data_out and lane_out hold while valid_out is low
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_out_r  <= {WIDTH{1'b0}};
      valid_out_r <= 1'b0;
      lane_out_r  <= {LW{1'b0}};
      overflow_r  <= 1'b0;
      aligned_r   <= 1'b0;
    end else begin
      if (pop_s) begin
        data_out_r  <= head_s;
        valid_out_r <= 1'b1;
        lane_out_r  <= rr_r;
      end else begin
        valid_out_r <= 1'b0;
      end
      overflow_r <= overflow_r | (|drop_s);
      aligned_r  <= (state_next_s == RUN);
    end
  end

  assign bus.data_out  = data_out_r;
  assign bus.valid_out = valid_out_r;
  assign bus.lane_out  = lane_out_r;
  assign bus.overflow  = overflow_r;
  assign bus.aligned   = aligned_r;

endmodule

// File: tb/tb_byte_unstriping_rx.sv
// -----------------------------------------------------------------------------
// tb_byte_unstriping_rx
// Directed bench for byte_unstriping_rx with LANES=4, WIDTH=8, DEPTH=4.
// A vector table covers the basic two-burst stream cycle by cycle; hand-made
// sequences cover lane skew, overflow, full-lane push+pop, mid-stream reset
// and a quiet link.
// -----------------------------------------------------------------------------
module tb_byte_unstriping_rx;
  logic clk;
  logic reset;

  byte_unstriping_rx_if #(.WIDTH(8), .LANES(4)) bus ();

  byte_unstriping_rx #(.WIDTH(8), .LANES(4), .DEPTH(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  vin;
    logic [31:0] din;
    logic        ev;
    logic [7:0]  ed;
    logic [1:0]  el;
    logic        eo;
    logic        ea;
  } vec_t;

  vec_t tbl [10];

  int checks;
  int errors;
  int cyc;
  int first_valid;
  logic [9:0] got   [$];
  logic [9:0] exp_q [$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // drive one cycle of lane inputs, then sample the outputs 1 time unit after the edge
  task automatic cycle(input logic [3:0] v, input logic [31:0] d);
    @(negedge clk);
    bus.valid_in = v;
    bus.data_in  = d;
    @(posedge clk);
    #1;
    if (bus.valid_out === 1'b1) begin
      got.push_back({bus.lane_out, bus.data_out});
      if (first_valid < 0) first_valid = cyc;
    end
    cyc++;
  endtask

  task automatic do_reset();
    bus.valid_in = 4'b0000;
    bus.data_in  = 32'h0000_0000;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    got.delete();
    exp_q.delete();
    cyc = 0;
    first_valid = -1;
  endtask

  task automatic expect_word(input int lane, input logic [7:0] d);
    exp_q.push_back({lane[1:0], d});
  endtask

  task automatic check_stream(input string nm);
    chk({nm, " count"}, got.size(), exp_q.size());
    for (int k = 0; k < exp_q.size(); k++) begin
      if (k < got.size()) chk({nm, " word"}, {22'd0, got[k]}, {22'd0, exp_q[k]});
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    cyc = 0;
    first_valid = -1;
    reset = 1'b0;
    bus.valid_in = 4'b0000;
    bus.data_in  = 32'h0000_0000;

    //            vin      din            ev    ed     el    eo    ea
    tbl[0] = '{4'b1111, 32'h1312_1110, 1'b0, 8'h00, 2'd0, 1'b0, 1'b0};
    tbl[1] = '{4'b1111, 32'h2322_2120, 1'b1, 8'h10, 2'd0, 1'b0, 1'b1};
    tbl[2] = '{4'b0000, 32'h0000_0000, 1'b1, 8'h11, 2'd1, 1'b0, 1'b1};
    tbl[3] = '{4'b0000, 32'h0000_0000, 1'b1, 8'h12, 2'd2, 1'b0, 1'b1};
    tbl[4] = '{4'b0000, 32'h0000_0000, 1'b1, 8'h13, 2'd3, 1'b0, 1'b1};
    tbl[5] = '{4'b0000, 32'h0000_0000, 1'b1, 8'h20, 2'd0, 1'b0, 1'b1};
    tbl[6] = '{4'b0000, 32'h0000_0000, 1'b1, 8'h21, 2'd1, 1'b0, 1'b1};
    tbl[7] = '{4'b0000, 32'h0000_0000, 1'b1, 8'h22, 2'd2, 1'b0, 1'b1};
    tbl[8] = '{4'b0000, 32'h0000_0000, 1'b1, 8'h23, 2'd3, 1'b0, 1'b1};
    tbl[9] = '{4'b0000, 32'h0000_0000, 1'b0, 8'h23, 2'd3, 1'b0, 1'b1};

    // reset values
    repeat (2) @(posedge clk);
    #1;
    chk("rst data_out", {24'd0, bus.data_out}, 32'h0);
    chk("rst valid_out", {31'd0, bus.valid_out}, 32'h0);
    chk("rst lane_out", {30'd0, bus.lane_out}, 32'h0);
    chk("rst overflow", {31'd0, bus.overflow}, 32'h0);
    chk("rst aligned", {31'd0, bus.aligned}, 32'h0);

    // basic two-burst stream, cycle-exact
    do_reset();
    for (int i = 0; i < 10; i++) begin
      cycle(tbl[i].vin, tbl[i].din);
      chk($sformatf("vec%0d valid_out", i), {31'd0, bus.valid_out}, {31'd0, tbl[i].ev});
      chk($sformatf("vec%0d data_out", i), {24'd0, bus.data_out}, {24'd0, tbl[i].ed});
      chk($sformatf("vec%0d lane_out", i), {30'd0, bus.lane_out}, {30'd0, tbl[i].el});
      chk($sformatf("vec%0d overflow", i), {31'd0, bus.overflow}, {31'd0, tbl[i].eo});
      chk($sformatf("vec%0d aligned", i), {31'd0, bus.aligned}, {31'd0, tbl[i].ea});
    end

    // lane 3 three cycles late
    do_reset();
    cycle(4'b0111, 32'h0012_1110);
    cycle(4'b0111, 32'h0022_2120);
    cycle(4'b0000, 32'h0000_0000);
    cycle(4'b1000, 32'h1300_0000);
    cycle(4'b1000, 32'h2300_0000);
    repeat (10) cycle(4'b0000, 32'h0000_0000);
    for (int r = 0; r < 2; r++)
      for (int l = 0; l < 4; l++) expect_word(l, 8'h10 + 8'(r * 16) + 8'(l));
    check_stream("skew");
    chk("skew overflow", {31'd0, bus.overflow}, 32'h0);
`ifdef BYTE_UNSTRIPE_ALIGN_EN
    chk("skew first valid cycle", first_valid, 4);
`else
    chk("skew first valid cycle", first_valid, 1);
`endif

    // lane 1 overflows while lane 0 is silent
    do_reset();
    for (int w = 0; w < 5; w++) begin
      cycle(4'b0010, {16'h0000, 8'hB0 + 8'(w), 8'h00});
      chk($sformatf("ovf%0d valid_out", w), {31'd0, bus.valid_out}, 32'h0);
      chk($sformatf("ovf%0d overflow", w), {31'd0, bus.overflow}, (w == 4) ? 32'h1 : 32'h0);
    end
    cycle(4'b1101, 32'h5352_0050);
    repeat (6) cycle(4'b0000, 32'h0000_0000);
    expect_word(0, 8'h50);
    expect_word(1, 8'hB0);
    expect_word(2, 8'h52);
    expect_word(3, 8'h53);
    check_stream("ovf");
    chk("ovf first valid cycle", first_valid, 6);
    chk("ovf sticky", {31'd0, bus.overflow}, 32'h1);

    // lane 0 full with simultaneous push and pop
    do_reset();
    cycle(4'b1111, 32'h0302_0100);
    cycle(4'b0001, 32'h0000_0040);
    cycle(4'b0001, 32'h0000_0041);
    cycle(4'b0001, 32'h0000_0042);
    cycle(4'b0001, 32'h0000_0043);
    cycle(4'b1111, 32'h5352_5144);
    chk("full pushpop overflow", {31'd0, bus.overflow}, 32'h0);
    cycle(4'b1110, 32'h6362_6100);
    cycle(4'b1110, 32'h7372_7100);
    cycle(4'b1110, 32'h8382_8100);
    repeat (15) cycle(4'b0000, 32'h0000_0000);
    for (int l = 0; l < 4; l++) expect_word(l, 8'(l));
    for (int r = 0; r < 5; r++) begin
      expect_word(0, 8'h40 + 8'(r));
      if (r < 4)
        for (int l = 1; l < 4; l++) expect_word(l, 8'h50 + 8'(r * 16) + 8'(l));
    end
    check_stream("full");
    chk("full overflow end", {31'd0, bus.overflow}, 32'h0);

    // asynchronous reset mid-stream
    do_reset();
    cycle(4'b1111, 32'h1312_1110);
    cycle(4'b1111, 32'h2322_2120);
    cycle(4'b1111, 32'h3332_3130);
    chk("pre-reset valid_out", {31'd0, bus.valid_out}, 32'h1);
    #2;
    reset = 1'b0;
    bus.valid_in = 4'b0000;
    #1;
    chk("async rst data_out", {24'd0, bus.data_out}, 32'h0);
    chk("async rst valid_out", {31'd0, bus.valid_out}, 32'h0);
    chk("async rst lane_out", {30'd0, bus.lane_out}, 32'h0);
    chk("async rst aligned", {31'd0, bus.aligned}, 32'h0);
    do_reset();
    cycle(4'b1111, 32'hA3A2_A1A0);
    repeat (7) cycle(4'b0000, 32'h0000_0000);
    for (int l = 0; l < 4; l++) expect_word(l, 8'hA0 + 8'(l));
    check_stream("post-reset");
    chk("post-reset first valid cycle", first_valid, 1);

    // quiet link after reset
    do_reset();
    for (int c = 0; c < 20; c++) begin
      cycle(4'b0000, 32'h0000_0000);
      chk($sformatf("quiet%0d valid_out", c), {31'd0, bus.valid_out}, 32'h0);
      chk($sformatf("quiet%0d overflow", c), {31'd0, bus.overflow}, 32'h0);
      chk($sformatf("quiet%0d aligned", c), {31'd0, bus.aligned}, 32'h0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
